uart_rx_frame_ctrl: RTL

Frame controller placed downstream of the 8n1 UART receiver, on the same clock. It consumes received bytes and their update strobe, hunts for a sync byte and parses an address/length/payload/checksum frame. Payload is buffered internally and written out as a register-write burst only after the checksum verifies. Failed frames are discarded with an error code, and a partial frame is never written.

---
 rtl/uart_rx_frame_ctrl.sv | 197 +++++++++++++++++++
 1 files changed

// File: rtl/uart_rx_frame_ctrl.sv
// Frame controller behind the 8n1 UART receiver: hunts SYNC, parses addr/len/payload/checksum,
// and bursts the buffered payload out as register writes only once the checksum verifies.
// Latency: first wr_en two clocks after the checksum byte event; burst is gap-free.
// Backpressure: none; a byte arriving during the burst is held in a one-entry pending slot.
// Ports: clk/rst (sync, active-high); rx_data/rx_stb byte input (rising edge of rx_stb = new byte);
//        wr_en/wr_addr/wr_data write burst; frame_ok/frame_err pulses; err_code held; busy = not hunting.
module uart_rx_frame_ctrl #(
  parameter logic [7:0] SYNC    = 8'hA5,
  parameter int         MAXLEN  = 16,
  parameter int         TIMEOUT = 1024
) (
  input  logic       clk,
  input  logic       rst,
  input  logic [7:0] rx_data,
  input  logic       rx_stb,
  output logic       wr_en,
  output logic [7:0] wr_addr,
  output logic [7:0] wr_data,
  output logic       frame_ok,
  output logic       frame_err,
  output logic [1:0] err_code,
  output logic       busy
);

  localparam int CW = $clog2(TIMEOUT + 1);
  localparam int AW = (MAXLEN > 1) ? $clog2(MAXLEN) : 1;
  localparam logic [7:0]    MAXLEN_B = 8'(MAXLEN);
  // Pulses are registered, so the abort is decided one count early to land
  // exactly TIMEOUT clocks after the last byte event.
  localparam logic [CW-1:0] TO_LAST  = CW'(TIMEOUT - 2);

  typedef enum logic [2:0] {HUNT, ADDR, LEN, DATA, CHK, COMMIT} state_t;

  state_t        state, state_n;
  logic          stb_d1, stb_d2, evt;
  logic [7:0]    base, base_n, len, len_n, sum, sum_n, idx, idx_n;
  logic [7:0]    idx_inc, chk_sum, byte_in;
  logic          take;
  logic [CW-1:0] cnt, cnt_n;
  logic          pend, pend_n;
  logic [7:0]    pend_byte, pend_byte_n;
  logic          wr_en_n, ok_n, err_n;
  logic [7:0]    wr_addr_n, wr_data_n;
  logic [1:0]    err_code_n;
  logic          mem_we;
  logic [7:0]    mem [MAXLEN];

  assign evt     = stb_d1 & ~stb_d2;
  assign idx_inc = idx + 8'd1;
  assign chk_sum = sum + rx_data;
  assign busy    = (state != HUNT);

  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= HUNT;
      stb_d1    <= 1'b0;
      stb_d2    <= 1'b0;
      base      <= '0;
      len       <= '0;
      sum       <= '0;
      idx       <= '0;
      cnt       <= '0;
      pend      <= 1'b0;
      pend_byte <= '0;
      wr_en     <= 1'b0;
      wr_addr   <= '0;
      wr_data   <= '0;
      frame_ok  <= 1'b0;
      frame_err <= 1'b0;
      err_code  <= '0;
    end else begin
      state     <= state_n;
      stb_d1    <= rx_stb;
      stb_d2    <= stb_d1;
      base      <= base_n;
      len       <= len_n;
      sum       <= sum_n;
      idx       <= idx_n;
      cnt       <= cnt_n;
      pend      <= pend_n;
      pend_byte <= pend_byte_n;
      wr_en     <= wr_en_n;
      wr_addr   <= wr_addr_n;
      wr_data   <= wr_data_n;
      frame_ok  <= ok_n;
      frame_err <= err_n;
      err_code  <= err_code_n;
    end
  end

  // Payload buffer; contents are meaningless outside a frame, so no reset.
  always_ff @(posedge clk) begin
    if (mem_we) mem[idx[AW-1:0]] <= rx_data;
  end

  always_comb begin
    state_n     = state;
    base_n      = base;
    len_n       = len;
    sum_n       = sum;
    idx_n       = idx;
    pend_n      = pend;
    pend_byte_n = pend_byte;
    wr_en_n     = 1'b0;
    wr_addr_n   = wr_addr;
    wr_data_n   = wr_data;
    ok_n        = 1'b0;
    err_n       = 1'b0;
    err_code_n  = err_code;
    mem_we      = 1'b0;
    take        = evt;
    byte_in     = rx_data;

    // A byte caught during the burst is replayed in HUNT; a live event takes priority.
    if (state == HUNT && !evt && pend) begin
      take    = 1'b1;
      byte_in = pend_byte;
    end

    if (state == HUNT || state == COMMIT || evt) cnt_n = '0;
    else                                         cnt_n = cnt + 1'b1;

    case (state)
      HUNT: begin
        pend_n = 1'b0;
        if (take && byte_in == SYNC) state_n = ADDR;
      end
      ADDR: begin
        if (evt) begin
          base_n  = rx_data;
          state_n = LEN;
        end
      end
      LEN: begin
        if (evt) begin
          len_n = rx_data;
          sum_n = base + rx_data;
          idx_n = '0;
          if (rx_data > MAXLEN_B) begin
            err_n      = 1'b1;
            err_code_n = 2'd2;
            state_n    = HUNT;
          end else if (rx_data == 8'd0) begin
            state_n = CHK;
          end else begin
            state_n = DATA;
          end
        end
      end
      DATA: begin
        if (evt) begin
          mem_we = 1'b1;
          sum_n  = chk_sum;
          idx_n  = idx_inc;
          if (idx_inc == len) state_n = CHK;
        end
      end
      CHK: begin
        if (evt) begin
          idx_n = '0;
          if (chk_sum == 8'd0) begin
            state_n = COMMIT;
          end else begin
            err_n      = 1'b1;
            err_code_n = 2'd1;
            state_n    = HUNT;
          end
        end
      end
      COMMIT: begin
        if (evt) begin
          pend_n      = 1'b1;
          pend_byte_n = rx_data;
        end
        if (idx == len) begin
          ok_n       = 1'b1;
          err_code_n = 2'd0;
          state_n    = HUNT;
        end else begin
          wr_en_n   = 1'b1;
          wr_addr_n = base + idx;
          wr_data_n = mem[idx[AW-1:0]];
          idx_n     = idx_inc;
        end
      end
      default: state_n = HUNT;
    endcase

    // Inter-byte timeout; a byte arriving in the same cycle wins.
    if ((state == ADDR || state == LEN || state == DATA || state == CHK) && !evt && cnt == TO_LAST) begin
      state_n    = HUNT;
      err_n      = 1'b1;
      err_code_n = 2'd3;
    end
  end

endmodule
